// File: rtl/matrix_cat_sched.sv
// Last-dimension concatenation sequencer for two MX block streams.
// Each output row takes IN0_ROW_BEATS blocks from port 0 and then IN1_ROW_BEATS
// blocks from port 1. After ROWS rows the final block is tagged "last" and the
// sequence starts over. Blocks pass through a single registered output stage.
//
// Handshake: a block moves on any rising edge where its valid and ready are both
// high. Ready never depends on the same port's valid. An output block with
// valid high and ready low holds every output register stable until accepted.
module matrix_cat_sched #(
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 8,
    parameter int BLOCK_SIZE    = 4,
    parameter int IN0_ROW_BEATS = 2,
    parameter int IN1_ROW_BEATS = 3,
    parameter int ROWS          = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAN_WIDTH-1:0] mdata_in_0 [BLOCK_SIZE],
    input  logic [EXP_WIDTH-1:0] edata_in_0,
    input  logic                 data_in_0_valid,
    output logic                 data_in_0_ready,
    input  logic [MAN_WIDTH-1:0] mdata_in_1 [BLOCK_SIZE],
    input  logic [EXP_WIDTH-1:0] edata_in_1,
    input  logic                 data_in_1_valid,
    output logic                 data_in_1_ready,
    output logic [MAN_WIDTH-1:0] mdata_out_0 [BLOCK_SIZE],
    output logic [EXP_WIDTH-1:0] edata_out_0,
    output logic                 data_out_0_valid,
    input  logic                 data_out_0_ready,
    output logic                 data_out_0_row_end,
    output logic                 data_out_0_last,
    output logic                 dbg_state
);

    localparam int MAX_BEATS = (IN0_ROW_BEATS > IN1_ROW_BEATS) ? IN0_ROW_BEATS : IN1_ROW_BEATS;
    localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
    localparam int ROW_W     = $clog2(ROWS + 1);
    localparam logic [BEAT_W-1:0] IN0_LAST = BEAT_W'(IN0_ROW_BEATS - 1);
    localparam logic [BEAT_W-1:0] IN1_LAST = BEAT_W'(IN1_ROW_BEATS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic {
        SEL_0 = 1'b0,
        SEL_1 = 1'b1
    } sel_e;

    sel_e                 state_q, state_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic [MAN_WIDTH-1:0] mdata_q [BLOCK_SIZE];
    logic [MAN_WIDTH-1:0] mdata_d [BLOCK_SIZE];
    logic [EXP_WIDTH-1:0] edata_q, edata_d;
    logic                 valid_q, valid_d;
    logic                 row_end_q, row_end_d;
    logic                 last_q, last_d;

    logic can_load;
    logic xfer_0;
    logic xfer_1;
    logic tag_row_end;
    logic tag_last;

    // The output register may take a new block when empty or being drained.
    assign can_load        = !valid_q || data_out_0_ready;
    assign data_in_0_ready = !rst && (state_q == SEL_0) && can_load;
    assign data_in_1_ready = !rst && (state_q == SEL_1) && can_load;
    assign xfer_0          = data_in_0_valid && data_in_0_ready;
    assign xfer_1          = data_in_1_valid && data_in_1_ready;

    // Port selection and beat/row counting; advances only on a handshake.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        row_cnt_d   = row_cnt_q;
        tag_row_end = 1'b0;
        tag_last    = 1'b0;
        case (state_q)
            SEL_0: begin
                if (xfer_0) begin
                    if (beat_cnt_q == IN0_LAST) begin
                        beat_cnt_d = '0;
                        state_d    = SEL_1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            SEL_1: begin
                if (xfer_1) begin
                    if (beat_cnt_q == IN1_LAST) begin
                        beat_cnt_d  = '0;
                        state_d     = SEL_0;
                        tag_row_end = 1'b1;
                        if (row_cnt_q == ROW_LAST) begin
                            tag_last  = 1'b1;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = SEL_0;
        endcase
    end

    // Output stage: hold under backpressure, load on transfer, else go empty.
    always_comb begin
        mdata_d   = mdata_q;
        edata_d   = edata_q;
        valid_d   = valid_q;
        row_end_d = row_end_q;
        last_d    = last_q;
        if (can_load) begin
            valid_d = xfer_0 || xfer_1;
            if (xfer_0) begin
                mdata_d   = mdata_in_0;
                edata_d   = edata_in_0;
                row_end_d = tag_row_end;
                last_d    = tag_last;
            end else if (xfer_1) begin
                mdata_d   = mdata_in_1;
                edata_d   = edata_in_1;
                row_end_d = tag_row_end;
                last_d    = tag_last;
            end
        end
    end

    // State, counters and output registers; reset drops any pending block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEL_0;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                mdata_q[i] <= '0;
            end
            edata_q    <= '0;
            valid_q    <= 1'b0;
            row_end_q  <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            mdata_q    <= mdata_d;
            edata_q    <= edata_d;
            valid_q    <= valid_d;
            row_end_q  <= row_end_d;
            last_q     <= last_d;
        end
    end

    assign mdata_out_0        = mdata_q;
    assign edata_out_0        = edata_q;
    assign data_out_0_valid   = valid_q;
    assign data_out_0_row_end = row_end_q;
    assign data_out_0_last    = last_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_matrix_cat_sched.sv
// Bench for matrix_cat_sched: random traffic against a position-based stream
// model, plus a degenerate 1/1/1 instance with hand-computed expectations.
module tb_matrix_cat_sched;

  localparam int IN0  = 2;
  localparam int IN1  = 3;
  localparam int NR   = 4;
  localparam int ROWB = IN0 + IN1;
  localparam int FULL = ROWB * NR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [7:0] m0 [4];
  logic [7:0] m1 [4];
  logic [7:0] e0, e1;
  logic       v0, v1, out_rdy;
  logic       r0, r1;
  logic [7:0] o_m [4];
  logic [7:0] o_e;
  logic       o_valid, o_re, o_last, dbg_main;

  matrix_cat_sched dut (
    .clk(clk), .rst(rst),
    .mdata_in_0(m0), .edata_in_0(e0), .data_in_0_valid(v0), .data_in_0_ready(r0),
    .mdata_in_1(m1), .edata_in_1(e1), .data_in_1_valid(v1), .data_in_1_ready(r1),
    .mdata_out_0(o_m), .edata_out_0(o_e), .data_out_0_valid(o_valid),
    .data_out_0_ready(out_rdy), .data_out_0_row_end(o_re), .data_out_0_last(o_last),
    .dbg_state(dbg_main)
  );

  // ---------------- degenerate DUT (1,1,1) ----------------
  logic [7:0] d_m0 [4];
  logic [7:0] d_m1 [4];
  logic [7:0] d_o_m [4];
  logic [7:0] d_o_e;
  logic       d_r0, d_r1, d_valid, d_re, d_last, dbg_deg;

  matrix_cat_sched #(.IN0_ROW_BEATS(1), .IN1_ROW_BEATS(1), .ROWS(1)) u_deg (
    .clk(clk), .rst(rst),
    .mdata_in_0(d_m0), .edata_in_0(8'h5A), .data_in_0_valid(1'b1), .data_in_0_ready(d_r0),
    .mdata_in_1(d_m1), .edata_in_1(8'hC3), .data_in_1_valid(1'b1), .data_in_1_ready(d_r1),
    .mdata_out_0(d_o_m), .edata_out_0(d_o_e), .data_out_0_valid(d_valid),
    .data_out_0_ready(1'b1), .data_out_0_row_end(d_re), .data_out_0_last(d_last),
    .dbg_state(dbg_deg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] src0_q[$];
  logic [39:0] src1_q[$];
  logic [41:0] exp_q[$];   // {row_end, last, exp, m3, m2, m1, m0}
  logic [9:0]  log_q[$];   // {exp, row_end, last} of every accepted output
  int  k_in  = 0;
  int  n_out = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;
  int  rate0 = 100, rate1 = 100, rate_out = 100;
  bit  auto_fill = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [39:0] pk(input logic [7:0] e, input logic [7:0] m [4]);
    return {e, m[3], m[2], m[1], m[0]};
  endfunction

  function automatic logic [39:0] mk(input logic [7:0] e);
    return {e, e ^ 8'h44, e ^ 8'h33, e ^ 8'h22, e ^ 8'h11};
  endfunction

  // ---------------- compare process ----------------
  // Output k of a matrix comes from port 0 when (k mod ROWB) < IN0, else port 1;
  // row_end at the end of each ROWB group, last at the end of each FULL group.
  always @(negedge clk) begin
    logic        ph1, exp_can;
    int          pos;
    logic [39:0] blk;
    if (rst) begin
      exp_q.delete();
      log_q.delete();
      k_in  = 0;
      n_out = 0;
      acc0  = 1'b0;
      acc1  = 1'b0;
    end else begin
      ph1     = ((k_in % FULL) % ROWB) >= IN0;
      exp_can = (exp_q.size() == 0) || out_rdy;
      chk("out_valid", 64'(o_valid), 64'(exp_q.size() != 0));
      if (o_valid && exp_q.size() != 0)
        chk("out_block", 64'({o_re, o_last, pk(o_e, o_m)}), 64'(exp_q[0]));
      chk("in0_ready", 64'(r0), 64'(exp_can && !ph1));
      chk("in1_ready", 64'(r1), 64'(exp_can && ph1));
      if (o_valid && out_rdy && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        log_q.push_back({o_e, o_re, o_last});
        n_out++;
      end
      acc0 = v0 && r0;
      acc1 = v1 && r1;
      if ((!ph1 && acc0) || (ph1 && acc1)) begin
        pos = k_in % FULL;
        blk = ph1 ? pk(e1, m1) : pk(e0, m0);
        exp_q.push_back({(pos % ROWB) == ROWB - 1, pos == FULL - 1, blk});
        k_in++;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    logic [39:0] junk;
    logic [39:0] tmp;
    v0 = 1'b0; v1 = 1'b0; out_rdy = 1'b1; e0 = '0; e1 = '0;
    for (int i = 0; i < 4; i++) begin
      m0[i] = '0; m1[i] = '0;
      d_m0[i] = 8'(8'h10 + i); d_m1[i] = 8'(8'h20 + i);
    end
    forever begin
      @(posedge clk);
      #1;
      if (acc0 && src0_q.size() > 0) junk = src0_q.pop_front();
      if (acc1 && src1_q.size() > 0) junk = src1_q.pop_front();
      if (auto_fill) begin
        while (src0_q.size() < 2) begin
          tmp = {$urandom(), 8'($urandom_range(0, 255))};
          src0_q.push_back(tmp);
        end
        while (src1_q.size() < 2) begin
          tmp = {$urandom(), 8'($urandom_range(0, 255))};
          src1_q.push_back(tmp);
        end
      end
      v0 = (src0_q.size() > 0) && (int'($urandom_range(0, 99)) < rate0);
      v1 = (src1_q.size() > 0) && (int'($urandom_range(0, 99)) < rate1);
      if (src0_q.size() > 0) begin
        e0 = src0_q[0][39:32];
        for (int i = 0; i < 4; i++) m0[i] = src0_q[0][8*i +: 8];
      end
      if (src1_q.size() > 0) begin
        e1 = src1_q[0][39:32];
        for (int i = 0; i < 4; i++) m1[i] = src1_q[0][8*i +: 8];
      end
      out_rdy = int'($urandom_range(0, 99)) < rate_out;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready0", 64'(r0), 64'd0);
    chk("rst_ready1", 64'(r1), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int cyc = 0;
    while (n_out < n && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (n_out < n) chk("wait_out_timeout", 64'(n_out), 64'(n));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lasts;
    // T1 preload: A0..A7 on port 0, B0..B11 on port 1.
    for (int i = 0; i < 8; i++) src0_q.push_back(mk(8'(8'hA0 + i)));
    for (int i = 0; i < 12; i++) src1_q.push_back(mk(8'(8'hB0 + i)));
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_edata", 64'(o_e), 64'd0);
    chk("reset_mdata0", 64'(o_m[0]), 64'd0);
    chk("reset_tags", 64'({o_re, o_last}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // T1 basic ordering and tags, hand-pinned.
    wait_out(20);
    chk("t1_count", 64'(log_q.size()), 64'd20);
    if (log_q.size() >= 20) begin
      chk("t1_first_A0", 64'(log_q[0][9:2]), 64'hA0);
      chk("t1_third_B0", 64'(log_q[2][9:2]), 64'hB0);
      chk("t1_sixth_A2", 64'(log_q[5][9:2]), 64'hA2);
      chk("t1_B2_tags", 64'(log_q[4][1:0]), 64'b10);
      chk("t1_B5_tags", 64'(log_q[9][1:0]), 64'b10);
      chk("t1_B10_tags", 64'(log_q[18][1:0]), 64'b00);
      chk("t1_B11_tags", 64'(log_q[19][1:0]), 64'b11);
      chk("t1_B11_data", 64'(log_q[19][9:2]), 64'hBB);
    end
    auto_fill = 1'b1;

    // T2 backpressure mid-row.
    wait_out(23);
    rate_out = 0;
    repeat (3) @(posedge clk);
    rate_out = 100;
    wait_out(32);

    // T4 two matrices back-to-back under random rates.
    rate0 = 70; rate1 = 70; rate_out = 70;
    do_reset();
    wait_out(40);
    lasts = 0;
    foreach (log_q[i]) if (log_q[i][0]) lasts++;
    chk("t4_last_count", 64'(lasts), 64'd2);
    if (log_q.size() >= 40) begin
      chk("t4_last_at_20", 64'(log_q[19][0]), 64'd1);
      chk("t4_last_at_40", 64'(log_q[39][0]), 64'd1);
    end

    // T5 reset after 3 output blocks, then restart.
    rate0 = 100; rate1 = 100; rate_out = 100;
    do_reset();
    wait_out(3);
    do_reset();
    rate0 = 60; rate1 = 80; rate_out = 50;
    wait_out(25);

    // T3 port-0 starvation right after reset while port 1 is valid.
    rate0 = 0; rate1 = 100; rate_out = 100;
    do_reset();
    repeat (5) @(posedge clk);
    chk("t3_no_output", 64'(n_out), 64'd0);
    rate0 = 100;
    wait_out(10);

    // Random soak segments.
    for (int s = 0; s < 6; s++) begin
      rate0 = int'($urandom_range(20, 100));
      rate1 = int'($urandom_range(20, 100));
      rate_out = int'($urandom_range(20, 100));
      wait_out(n_out + 30);
    end

    // T6 degenerate instance: strict A,B alternation with row_end and last on B.
    rate_out = 100;
    do_reset();
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_valid", 64'(d_valid), 64'd1);
      chk("t6_edata", 64'(d_o_e), (i % 2 == 0) ? 64'h5A : 64'hC3);
      chk("t6_tags", 64'({d_re, d_last}), (i % 2 == 0) ? 64'b00 : 64'b11);
      chk("t6_mdata0", 64'(d_o_m[0]), (i % 2 == 0) ? 64'h10 : 64'h20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
